uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmit byte channel between two requesters.
- Keyboard path: scancode-to-ASCII/escape sequences.
- Terminal response path: VT100 replies such as the cursor position report to ESC[6n and device attributes.
Arbitration is packet-atomic, so a multi-byte escape sequence from one source is never interleaved with bytes from the other. The block sits between the keyboard/VT100 byte sources and the UART transmitter core, in the clk100M domain.

Parameters:
TimeoutCycles, 1_000_000, cycles an owner may leave valid low mid-packet before its grant is revoked (10 ms at 100 MHz)
RspFirst, 1, priority after reset: 1 = response source, 0 = keyboard

Ports:
clk100M  in  1  system clock
rst  in  1  reset; synchronous, active-low
kbd_data  in  8  keyboard byte
kbd_last  in  1  kbd_data is the final byte of its packet
kbd_valid  in  1  keyboard byte present
kbd_ready  out  1  keyboard byte accepted this cycle when valid&ready
rsp_data  in  8  terminal response byte
rsp_last  in  1  final byte of response packet
rsp_valid  in  1  response byte present
rsp_ready  out  1  response byte accepted when valid&ready
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART transmitter accepts tx_data this cycle
grant  out  2  current owner: 00 none, 01 kbd, 10 rsp
timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (rst==0 at clk100M edge):
  - state=IDLE; tx_valid=0; tx_data=0; grant=00; timeout_pulse=0.
  - Priority pointer set per RspFirst; timeout counter=0.
  - A reset mid-packet discards the held byte and the remainder of the packet.
- States: IDLE, OWN_KBD, OWN_RSP.
- IDLE:
  - kbd_ready=rsp_ready=0.
  - Only one valid → move to that owner next cycle.
  - Both valid → move to the source named by the priority pointer.
  - Neither valid → stay.
  - The grant cycle costs exactly one cycle.
- Owner state:
  - owner_ready = !tx_valid | tx_ready.
  - Non-owner ready=0.
  - grant reflects the state combinationally from registered state.
- Output register (one entry):
  - On owner valid&ready: tx_data<=data and tx_valid<=1 on the next edge.
  - Latency is 1 cycle from acceptance to tx_valid.
  - tx_valid&tx_ready with no new load: tx_valid<=0.
  - tx_ready held high gives 1 byte/cycle throughput.
  - tx_data must stay stable while tx_valid&!tx_ready.
- Packet end:
  - Accepting a byte with last=1 → state<=IDLE.
  - Pointer<=the other source (round robin).
  - The final byte still drains through the output register normally.
  - The next grant may occur while that byte is waiting on tx_ready.
- Timeout:
  - In an owner state the counter increments each cycle owner_valid==0, and clears on every accepted byte and on entry to the state.
  - Counter reaching TimeoutCycles-1 while valid is still low:
    - state<=IDLE; pointer<=other source; timeout_pulse=1 for one cycle; counter<=0.
  - Stalls caused by tx_ready=0 (owner valid high) never count toward timeout.
  - Counter width is $clog2(TimeoutCycles).
- Boundaries:
  - Single-byte packet (last on first byte): grant and release in consecutive cycles.
  - Source drops valid before acceptance: no effect; the byte is not taken.
  - The non-owner may hold valid indefinitely; it is served after the current packet.
  - A source that does not own the grant never sees ready=1.
- No state change occurs on invalid grant encodings; the 11 encoding is unreachable.

Test Plan:
- Reset then single kbd packet 0x41(last), tx_ready=1:
  - grant=01 one cycle after kbd_valid.
  - tx_valid=1 with tx_data=0x41 one cycle after acceptance.
  - grant=00 the following cycle.
- Both valid from IDLE with RspFirst=1, rsp=1B 5B 32 34 3B 38 30 52 (last on 0x52), kbd=0x61:
  - tx sequence is all eight rsp bytes contiguously, then 0x61.
  - kbd_ready=0 throughout the rsp packet.
- Continuous contention, each source sending 2-byte packets:
  - Output alternates packets rsp,kbd,rsp,kbd.
  - No packet is split.
- tx_ready toggling 0/1 every cycle during kbd packet 1B 5B 41:
  - All bytes delivered in order, none duplicated.
  - tx_data stable while tx_valid&!tx_ready.
  - No timeout fires.
- TimeoutCycles=16: kbd sends 0x1B (last=0), then drops valid with rsp_valid=1:
  - timeout_pulse exactly 16 cycles after the last acceptance.
  - grant→00, then 10.
  - rsp packet transmitted.
- rst=0 asserted with tx_valid=1 mid-packet:
  - Next cycle tx_valid=0, grant=00.
  - After release, the pending kbd packet restarts from a fresh grant.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit byte channel between the keyboard
// byte source and the VT100 response source. Ownership is held for a whole
// packet (up to the byte flagged last) so escape sequences never interleave.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no owner; choose the next source (costs one cycle)
// OWN_KBD  | keyboard owns the channel until its last byte or a timeout
// OWN_RSP  | response source owns the channel until its last byte or a timeout
module uart_tx_arbiter #(
  parameter int unsigned TimeoutCycles = 1_000_000,
  parameter bit          RspFirst      = 1'b1
) (
  input  logic       clk100M,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_last,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic [7:0] rsp_data,
  input  logic       rsp_last,
  input  logic       rsp_valid,
  output logic       rsp_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       timeout_pulse
);

  localparam int unsigned     CntW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  // Encoding matches the grant output so the owner is visible directly.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN_KBD = 2'b01,
    OWN_RSP = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ptr_rsp;
  logic [CntW-1:0] idle_cnt;
  logic            own_state;
  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            own_ready;
  logic            accept;
  logic            pkt_done;
  logic            timeout_hit;

  // Select the current owner's byte stream.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    case (state)
      OWN_KBD: begin
        own_valid = kbd_valid;
        own_last  = kbd_last;
        own_data  = kbd_data;
      end
      OWN_RSP: begin
        own_valid = rsp_valid;
        own_last  = rsp_last;
        own_data  = rsp_data;
      end
      default: ;
    endcase
  end

  assign own_state   = (state == OWN_KBD) || (state == OWN_RSP);
  assign own_ready   = !tx_valid || tx_ready;
  assign accept      = own_state && own_valid && own_ready;
  assign pkt_done    = accept && own_last;
  // Only a silent owner times out; a stalled transmitter never does.
  assign timeout_hit = own_state && !own_valid && (idle_cnt == CntMax);

  // State register.
  always_ff @(posedge clk100M) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: grant from IDLE, release on last byte or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (kbd_valid && rsp_valid) state_nxt = ptr_rsp ? OWN_RSP : OWN_KBD;
        else if (kbd_valid)         state_nxt = OWN_KBD;
        else if (rsp_valid)         state_nxt = OWN_RSP;
      end
      OWN_KBD, OWN_RSP: begin
        if (pkt_done || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = state;
    endcase
  end

  // Outputs decoded from the registered state: grant and per-source ready.
  always_comb begin
    grant     = 2'b00;
    kbd_ready = 1'b0;
    rsp_ready = 1'b0;
    case (state)
      OWN_KBD: begin
        grant     = 2'b01;
        kbd_ready = own_ready;
      end
      OWN_RSP: begin
        grant     = 2'b10;
        rsp_ready = own_ready;
      end
      default: ;
    endcase
  end

  // Round-robin pointer, silent-owner counter and timeout pulse.
  always_ff @(posedge clk100M) begin
    if (!rst) begin
      ptr_rsp       <= RspFirst;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (pkt_done || timeout_hit) ptr_rsp <= (state == OWN_KBD);
      if (!own_state || accept || timeout_hit) idle_cnt <= '0;
      else if (!own_valid)                     idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // One-entry output register; tx_data holds while the transmitter stalls.
  always_ff @(posedge clk100M) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (accept) begin
      tx_valid <= 1'b1;
      tx_data  <= own_data;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus a randomized packet run for
// uart_tx_arbiter. Sources are modelled as packet queues; the transmitted
// stream is checked against whole packets tagged by source.
module tb_uart_tx_arbiter;

  logic       clk100M = 1'b0;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_last;
  logic       kbd_valid;
  logic       kbd_ready;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] grant;
  logic       timeout_pulse;

  always #5 clk100M = ~clk100M;

  uart_tx_arbiter #(.TimeoutCycles(16), .RspFirst(1'b1)) dut (
    .clk100M      (clk100M),
    .rst          (rst),
    .kbd_data     (kbd_data),
    .kbd_last     (kbd_last),
    .kbd_valid    (kbd_valid),
    .kbd_ready    (kbd_ready),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .grant        (grant),
    .timeout_pulse(timeout_pulse)
  );

  int tests = 0;
  int fails = 0;

  // {last, data} entries still to be offered by each source
  logic [8:0] kq[$];
  logic [8:0] rq[$];
  // expected packets for the randomized run
  logic [8:0] kexp[$];
  logic [8:0] rexp[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];

  bit         kbd_en;
  bit         rsp_en;
  bit         rand_valid;
  int         tx_mode;   // 0 always ready, 1 toggle, 2 random, 3 stalled
  int         kgap;
  int         rgap;
  int         cyc;
  int         to_cnt;
  bit         prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive sources, record handshakes, pass one rising edge.
  task automatic tick();
    bit kv;
    bit rv;
    kv = kbd_en && (kq.size() > 0);
    rv = rsp_en && (rq.size() > 0);
    if (rand_valid) begin
      if (kv && kgap < 3 && $urandom_range(3) == 0) begin kv = 1'b0; kgap++; end
      else kgap = 0;
      if (rv && rgap < 3 && $urandom_range(3) == 0) begin rv = 1'b0; rgap++; end
      else rgap = 0;
    end
    kbd_valid = kv;
    kbd_data  = kv ? kq[0][7:0] : 8'h00;
    kbd_last  = kv ? kq[0][8]   : 1'b0;
    rsp_valid = rv;
    rsp_data  = rv ? rq[0][7:0] : 8'h00;
    rsp_last  = rv ? rq[0][8]   : 1'b0;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = !tx_ready;
      2:       tx_ready = 1'($urandom_range(1));
      default: tx_ready = 1'b0;
    endcase
    #1;
    if (prev_stall) begin
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, prev_data);
    end
    chk("kbd_ready_only_owner", kbd_ready && (grant != 2'b01), 0);
    chk("rsp_ready_only_owner", rsp_ready && (grant != 2'b10), 0);
    if (rst && kbd_valid && kbd_ready) void'(kq.pop_front());
    if (rst && rsp_valid && rsp_ready) void'(rq.pop_front());
    if (rst && tx_valid && tx_ready) out_q.push_back(tx_data);
    prev_stall = rst && tx_valid && !tx_ready;
    prev_data  = tx_data;
    @(negedge clk100M);
    cyc++;
    if (timeout_pulse) to_cnt++;
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((kq.size() > 0 || rq.size() > 0 || tx_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, (kq.size() == 0) && (rq.size() == 0) && !tx_valid, 1);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) chk(tag, out_q[i], exp_q[i]);
  endtask

  initial begin
    int         to_before;
    int         pulse_at;
    logic [1:0] g16;
    logic [1:0] g17;
    int         len;
    int         idx;
    bit         src_rsp;
    logic [8:0] e;
    logic [7:0] b;

    rst = 1'b0; kbd_en = 1'b1; rsp_en = 1'b1; rand_valid = 1'b0; tx_mode = 0;
    kbd_valid = 1'b0; kbd_data = 8'h00; kbd_last = 1'b0;
    rsp_valid = 1'b0; rsp_data = 8'h00; rsp_last = 1'b0; tx_ready = 1'b1;
    kgap = 0; rgap = 0; cyc = 0; to_cnt = 0; prev_stall = 1'b0; prev_data = 8'h00;
    g16 = 2'b11; g17 = 2'b11;
    @(negedge clk100M);

    // reset state
    tick(); tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_pulse", timeout_pulse, 0);
    chk("rst_kbd_ready", kbd_ready, 0);
    chk("rst_rsp_ready", rsp_ready, 0);

    // single-byte keyboard packet
    rst = 1'b1;
    tick();
    chk("t1_idle_grant", grant, 0);
    kq.push_back({1'b1, 8'h41});
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_kbd_ready", kbd_ready, 1);
    chk("t1_txv_before", tx_valid, 0);
    tick();
    chk("t1_txv", tx_valid, 1);
    chk("t1_txd", tx_data, 8'h41);
    chk("t1_release", grant, 0);
    tick();
    chk("t1_drained", tx_valid, 0);
    exp_q = '{8'h41};
    chk_seq("t1_seq");

    // both valid from IDLE: response wins and is sent whole
    out_q.delete();
    rq.push_back({1'b0, 8'h1B}); rq.push_back({1'b0, 8'h5B}); rq.push_back({1'b0, 8'h32});
    rq.push_back({1'b0, 8'h34}); rq.push_back({1'b0, 8'h3B}); rq.push_back({1'b0, 8'h38});
    rq.push_back({1'b0, 8'h30}); rq.push_back({1'b1, 8'h52});
    kq.push_back({1'b1, 8'h61});
    drain(100, "t2_done");
    exp_q = '{8'h1B, 8'h5B, 8'h32, 8'h34, 8'h3B, 8'h38, 8'h30, 8'h52, 8'h61};
    chk_seq("t2_seq");

    // continuous contention with 2-byte packets alternates sources
    out_q.delete();
    rq.push_back({1'b0, 8'hA0}); rq.push_back({1'b1, 8'hA1});
    rq.push_back({1'b0, 8'hA2}); rq.push_back({1'b1, 8'hA3});
    kq.push_back({1'b0, 8'h10}); kq.push_back({1'b1, 8'h11});
    kq.push_back({1'b0, 8'h12}); kq.push_back({1'b1, 8'h13});
    drain(100, "t3_done");
    exp_q = '{8'hA0, 8'hA1, 8'h10, 8'h11, 8'hA2, 8'hA3, 8'h12, 8'h13};
    chk_seq("t3_seq");

    // toggling tx_ready during a keyboard escape sequence
    out_q.delete();
    to_before = to_cnt;
    tx_mode = 1;
    kq.push_back({1'b0, 8'h1B}); kq.push_back({1'b0, 8'h5B}); kq.push_back({1'b1, 8'h41});
    drain(100, "t4_done");
    exp_q = '{8'h1B, 8'h5B, 8'h41};
    chk_seq("t4_seq");
    chk("t4_no_timeout", to_cnt - to_before, 0);
    tx_mode = 0;

    // silent keyboard owner times out; waiting response is then served
    out_q.delete();
    rsp_en = 1'b0;
    rq.push_back({1'b0, 8'hC1}); rq.push_back({1'b1, 8'hC2});
    kq.push_back({1'b0, 8'h1B});
    for (int i = 0; i < 10 && kq.size() > 0; i++) tick();
    chk("t5_kbd_accepted", kq.size(), 0);
    rsp_en = 1'b1;
    to_before = to_cnt;
    pulse_at = -1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (timeout_pulse && pulse_at < 0) pulse_at = k;
      if (k == 16) g16 = grant;
      if (k == 17) g17 = grant;
    end
    chk("t5_pulse_cycle", pulse_at, 16);
    chk("t5_pulse_count", to_cnt - to_before, 1);
    chk("t5_grant_idle", g16, 2'b00);
    chk("t5_grant_rsp", g17, 2'b10);
    drain(50, "t5_done");
    exp_q = '{8'h1B, 8'hC1, 8'hC2};
    chk_seq("t5_seq");

    // reset mid-packet with a byte held in the output register
    out_q.delete();
    tx_mode = 3;
    kq.push_back({1'b0, 8'h1B}); kq.push_back({1'b0, 8'h5B}); kq.push_back({1'b1, 8'h41});
    tick(); tick();
    chk("t6_held", tx_valid, 1);
    rst = 1'b0;
    tick();
    chk("t6_rst_txv", tx_valid, 0);
    chk("t6_rst_grant", grant, 0);
    kq.delete();
    kq.push_back({1'b0, 8'h1B}); kq.push_back({1'b0, 8'h5B}); kq.push_back({1'b1, 8'h41});
    rst = 1'b1;
    tx_mode = 0;
    tick();
    chk("t6_fresh_grant", grant, 2'b01);
    drain(50, "t6_done");
    exp_q = '{8'h1B, 8'h5B, 8'h41};
    chk_seq("t6_seq");

    // randomized packets, valid gaps and transmitter stalls
    out_q.delete();
    to_before = to_cnt;
    rand_valid = 1'b1;
    tx_mode = 2;
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(4, 1);
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom_range(127));
        kq.push_back({j == len - 1, b});
        kexp.push_back({j == len - 1, b});
      end
      len = $urandom_range(4, 1);
      for (int j = 0; j < len; j++) begin
        b = 8'h80 | 8'($urandom_range(127));
        rq.push_back({j == len - 1, b});
        rexp.push_back({j == len - 1, b});
      end
    end
    drain(3000, "t7_done");
    chk("t7_no_timeout", to_cnt - to_before, 0);
    idx = 0;
    while (idx < out_q.size()) begin
      src_rsp = out_q[idx][7];
      chk("t7_src_has_bytes", (src_rsp ? rexp.size() : kexp.size()) != 0, 1);
      if ((src_rsp ? rexp.size() : kexp.size()) == 0) break;
      e = 9'h000;
      while (idx < out_q.size()) begin
        if (src_rsp) e = rexp.pop_front();
        else         e = kexp.pop_front();
        chk("t7_byte", out_q[idx], e[7:0]);
        idx++;
        if (e[8] || (src_rsp ? rexp.size() : kexp.size()) == 0) break;
      end
      chk("t7_pkt_complete", e[8], 1);
    end
    chk("t7_kbd_left", kexp.size(), 0);
    chk("t7_rsp_left", rexp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
